sqrt_display: RTL and testbench

//  Result display stage downstream of the square-root datapath/controller.
//  - On the controller's done pulse, captures the operand a[7:0] and the result sqrt[3:0].
//  - Converts the operand to 3 BCD digits with a sequential double-dabble.
//  - Converts sqrt to 2 BCD digits.
//  - Drives a 4-digit multiplexed, active-low seven-segment display.

---
 rtl/sqrt_display.sv | 240 ++++++++++++++++++++++++
 tb/tb_sqrt_display.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_display.sv
// Result display stage for the square-root unit.
// Captures operand a and result sqrt on the controller's done pulse. The
// operand is converted to three BCD digits by a sequential double-dabble,
// and sqrt is split into two BCD digits. Both are shown on a 4-digit,
// multiplexed, active-low seven-segment display.
// Ports:
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   done       one-cycle capture strobe for a / sqrt
//   a          8-bit operand
//   sqrt       4-bit result
//   show_sqrt  0: show operand, 1: show sqrt
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   an         digit anodes, active-low
//   dp         decimal point, active-low, held off
//   busy       conversion in progress
//   bcd_valid  a conversion has completed since reset
module sqrt_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       done,
    input  logic [7:0] a,
    input  logic [3:0] sqrt,
    input  logic       show_sqrt,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy,
    output logic       bcd_valid
);

    localparam int unsigned ITER_W = 3;
    localparam int unsigned BCD_W  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          sh_q, sh_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                pend_st_q, pend_st_d;
    logic [3:0]          pend_so_q, pend_so_d;
    logic [3:0]          disp_h_q, disp_h_d;
    logic [3:0]          disp_t_q, disp_t_d;
    logic [3:0]          disp_o_q, disp_o_d;
    logic                disp_st_q, disp_st_d;
    logic [3:0]          disp_so_q, disp_so_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [3:0]          an_q, an_d;

    logic [BCD_W-1:0]    adj_c;
    logic [BCD_W+7:0]    shifted_c;
    logic                wrap_c;
    logic                lit_c;
    logic [3:0]          digit_c;

    // Active-low gfedcba pattern for a BCD digit
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // One double-dabble step: add-3 correction, then shift
    always_comb begin
        adj_c = bcd_q;
        for (int n = 0; n < 3; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) begin
                adj_c[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
            end
        end
        shifted_c = {adj_c, sh_q} << 1;
    end

    // Capture / conversion FSM
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bcd_d     = bcd_q;
        iter_d    = iter_q;
        pend_st_d = pend_st_q;
        pend_so_d = pend_so_q;
        disp_h_d  = disp_h_q;
        disp_t_d  = disp_t_q;
        disp_o_d  = disp_o_q;
        disp_st_d = disp_st_q;
        disp_so_d = disp_so_q;
        busy_d    = busy_q;
        valid_d   = valid_q;

        if (done) begin
            // A new capture always wins, including an abort of a running conversion
            sh_d      = a;
            bcd_d     = '0;
            iter_d    = '0;
            pend_st_d = (sqrt >= 4'd10);
            pend_so_d = (sqrt >= 4'd10) ? sqrt - 4'd10 : sqrt;
            busy_d    = 1'b1;
            state_d   = CONV;
        end else begin
            case (state_q)
                IDLE, SHOW: ;
                CONV: begin
                    {bcd_d, sh_d} = shifted_c;
                    iter_d        = iter_q + ITER_W'(1);
                    if (iter_q == ITER_W'(7)) begin
                        // Display registers change only here, as one update
                        disp_h_d  = shifted_c[19:16];
                        disp_t_d  = shifted_c[15:12];
                        disp_o_d  = shifted_c[11:8];
                        disp_st_d = pend_st_q;
                        disp_so_d = pend_so_q;
                        busy_d    = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = SHOW;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Digit content for the index about to be shown
    always_comb begin
        lit_c   = 1'b0;
        digit_c = 4'd0;
        if (show_sqrt) begin
            case (idx_d)
                2'd0: begin digit_c = disp_so_q;          lit_c = 1'b1;      end
                2'd1: begin digit_c = {3'b000, disp_st_q}; lit_c = disp_st_q; end
                default: lit_c = 1'b0;
            endcase
        end else begin
            case (idx_d)
                2'd0: begin digit_c = disp_o_q; lit_c = 1'b1; end
                2'd1: begin
                    digit_c = disp_t_q;
                    lit_c   = (disp_h_q != 4'd0) || (disp_t_q != 4'd0);
                end
                2'd2: begin digit_c = disp_h_q; lit_c = (disp_h_q != 4'd0); end
                default: lit_c = 1'b0;
            endcase
        end
    end

    // Refresh counter, digit index and registered segment/anode drive
    always_comb begin
        wrap_c = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        seg_d  = seg_q;
        an_d   = an_q;
        if (wrap_c) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        if (wrap_c) begin
            an_d = 4'hF;
            if (!valid_q) begin
                seg_d       = 7'h3F;
                an_d[idx_d] = 1'b0;
            end else if (lit_c) begin
                seg_d       = seg_of(digit_c);
                an_d[idx_d] = 1'b0;
            end else begin
                seg_d = 7'h7F;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            pend_st_q <= 1'b0;
            pend_so_q <= '0;
            disp_h_q  <= '0;
            disp_t_q  <= '0;
            disp_o_q  <= '0;
            disp_st_q <= 1'b0;
            disp_so_q <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_q     <= 7'h7F;
            an_q      <= 4'hF;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bcd_q     <= bcd_d;
            iter_q    <= iter_d;
            pend_st_q <= pend_st_d;
            pend_so_q <= pend_so_d;
            disp_h_q  <= disp_h_d;
            disp_t_q  <= disp_t_d;
            disp_o_q  <= disp_o_d;
            disp_st_q <= disp_st_d;
            disp_so_q <= disp_so_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign dp        = 1'b1;
    assign busy      = busy_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_sqrt_display.sv
// Self-checking bench for sqrt_display with a fast refresh (REFRESH_DIV=4).
module tb_sqrt_display;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       done;
    logic [7:0] a;
    logic [3:0] sqrt;
    logic       show_sqrt;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;
    logic       bcd_valid;

    int n_cmp = 0;
    int n_bad = 0;

    sqrt_display #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
        .clk(clk), .clr(clr), .done(done), .a(a), .sqrt(sqrt),
        .show_sqrt(show_sqrt), .seg(seg), .an(an), .dp(dp),
        .busy(busy), .bcd_valid(bcd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; 9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    int         m_cnt, m_idx, m_left, m_pa, m_ps;
    int         m_h, m_t, m_o, m_st, m_so;
    logic       m_busy, m_valid;
    logic [6:0] m_seg;
    logic [3:0] m_an;

    always @(posedge clk or negedge clr) begin : model
        int   ni, dval;
        logic lit;
        logic [3:0] nan;
        if (!clr) begin
            m_cnt <= 0; m_idx <= 0; m_left <= 0; m_pa <= 0; m_ps <= 0;
            m_h <= 0; m_t <= 0; m_o <= 0; m_st <= 0; m_so <= 0;
            m_busy <= 1'b0; m_valid <= 1'b0; m_seg <= 7'h7F; m_an <= 4'hF;
        end else begin
            if (m_cnt == DIV - 1) begin
                m_cnt <= 0;
                ni = (m_idx + 1) % 4;
                m_idx <= ni;
                lit = 1'b0; dval = 0;
                if (!m_valid) lit = 1'b1;
                else if (!show_sqrt) begin
                    if (ni == 0) begin lit = 1'b1; dval = m_o; end
                    if (ni == 1) begin lit = (m_h * 10 + m_t) > 0; dval = m_t; end
                    if (ni == 2) begin lit = m_h > 0; dval = m_h; end
                end else begin
                    if (ni == 0) begin lit = 1'b1; dval = m_so; end
                    if (ni == 1) begin lit = m_st > 0; dval = m_st; end
                end
                nan = 4'hF;
                if (lit) nan[ni] = 1'b0;
                m_an  <= nan;
                m_seg <= !lit ? 7'h7F : (!m_valid ? 7'h3F : seg7(dval));
            end else begin
                m_cnt <= m_cnt + 1;
            end
            if (done) begin
                m_pa <= int'(a); m_ps <= int'(sqrt); m_left <= 8; m_busy <= 1'b1;
            end else if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_valid <= 1'b1;
                    m_h <= m_pa / 100; m_t <= (m_pa / 10) % 10; m_o <= m_pa % 10;
                    m_st <= m_ps / 10; m_so <= m_ps % 10;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("seg", 32'(seg), 32'(m_seg));
        check("an", 32'(an), 32'(m_an));
        check("dp", 32'(dp), 32'd1);
        check("busy", 32'(busy), 32'(m_busy));
        check("bcd_valid", 32'(bcd_valid), 32'(m_valid));
        check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse(input logic [7:0] av, input logic [3:0] sv);
        tick();
        done = 1'b1; a = av; sqrt = sv;
        tick();
        done = 1'b0; a = 8'hXX; sqrt = 4'hX;
    endtask

    // Capture and check busy timeline: high right after edge N through N+7, low at N+8
    task automatic conv_check(input logic [7:0] av, input logic [3:0] sv, input string nm);
        pulse(av, sv);
        check({nm, "_busy_N"}, 32'(busy), 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick();
            check({nm, "_busy_mid"}, 32'(busy), 32'd1);
        end
        tick();
        check({nm, "_busy_end"}, 32'(busy), 32'd0);
        check({nm, "_valid_end"}, 32'(bcd_valid), 32'd1);
    endtask

    // Let at least one index advance pass, then wait for a digit and check its pattern
    task automatic wait_an(input logic [3:0] tgt, input logic [6:0] exp, input string nm);
        int k;
        repeat (DIV + 1) tick();
        k = 0;
        while (an !== tgt && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout waiting for an=%b (an=%b)", nm, tgt, an);
        end else begin
            check(nm, 32'(seg), 32'(exp));
        end
    endtask

    initial begin
        logic [3:0] prev;
        int         gap;
        clr = 1'b0; done = 1'b0; a = '0; sqrt = '0; show_sqrt = 1'b0;
        repeat (3) tick();
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        clr = 1'b1;
        wait_an(4'b1110, 7'h3F, "dash_d0");

        // 200 / 14
        conv_check(8'd200, 4'd14, "c200");
        check("model_h200", 32'(m_h), 32'd2);
        check("model_t200", 32'(m_t), 32'd0);
        check("model_o200", 32'(m_o), 32'd0);
        wait_an(4'b1011, 7'h24, "a200_d2");
        wait_an(4'b1101, 7'h40, "a200_d1");
        wait_an(4'b1110, 7'h40, "a200_d0");
        show_sqrt = 1'b1;
        wait_an(4'b1101, 7'h79, "s14_d1");
        wait_an(4'b1110, 7'h19, "s14_d0");

        // 7 / 2, toggling the source while idle
        show_sqrt = 1'b0;
        conv_check(8'd7, 4'd2, "c7");
        wait_an(4'b1110, 7'h78, "a7_d0");
        show_sqrt = 1'b1;
        wait_an(4'b1110, 7'h24, "s2_d0");
        show_sqrt = 1'b0;
        wait_an(4'b1110, 7'h78, "a7_back");

        // 255 aborted by 16 three cycles later
        pulse(8'd255, 4'd15);
        repeat (2) tick();
        conv_check(8'd16, 4'd4, "c16");
        check("model_t16", 32'(m_t), 32'd1);
        check("model_o16", 32'(m_o), 32'd6);
        wait_an(4'b1101, 7'h79, "a16_d1");
        wait_an(4'b1110, 7'h02, "a16_d0");
        repeat (20) tick();

        // Reset in the middle of a conversion
        pulse(8'd200, 4'd14);
        repeat (3) tick();
        clr = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_valid", 32'(bcd_valid), 32'd0);
        check("mid_an", 32'(an), 32'hF);
        check("mid_seg", 32'(seg), 32'h7F);
        repeat (2) tick();
        clr = 1'b1;

        // Scan cadence and order on dashes
        gap = 0;
        while (an === 4'hF && gap < 10) begin tick(); gap++; end
        check("first_adv", 32'(an), 32'b1101);
        for (int s = 0; s < 4; s++) begin
            prev = an;
            gap = 0;
            while (an === prev && gap < 10) begin tick(); gap++; end
            check("scan_gap", 32'(gap), 32'(DIV));
            check("scan_order", 32'(an), 32'({prev[2:0], prev[3]}));
            check("scan_dash", 32'(seg), 32'h3F);
        end

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
